// File: rtl/seg7_scan_if.sv
// Display-side bundle between the GPIO 7-seg register (master) and the
// scan driver (slave).
interface seg7_scan_if;
    // No valid/ready pair: disp_num/point/le are level signals that the
    // driver samples once per frame at LOAD; an/seg/frame_done are
    // continuously driven registered outputs.
    logic [31:0] disp_num;
    logic [7:0]  point;
    logic [7:0]  le;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    modport master (output disp_num, point, le, input an, seg, frame_done);
    modport slave  (input disp_num, point, le, output an, seg, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan driver with per-slot blanking.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus,
    output logic [1:0]  dbg_state
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    digit;
    logic [31:0]   snapshot;
    logic [7:0]    point_q;
    logic [7:0]    le_q;
    logic [7:0]    dark_q;
    logic [7:0]    an_q;
    logic [7:0]    seg_q;
    logic          frame_done_q;
    logic [3:0]    nib;
    logic          lit;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            default: dec = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_LZB_EN
    // dark[d] marks a leading zero: nibbles d..7 all zero; digit 0 never dark.
    logic [7:0] lz_mask;
    always_comb begin
        lz_mask = 8'h00;
        for (int d = 1; d < 8; d++) begin
            lz_mask[d] = ((bus.disp_num >> (4 * d)) == 32'd0);
        end
    end
`else
    assign dark_q = 8'h00;
`endif

    assign nib = snapshot[{digit, 2'b00} +: 4];
    assign lit = le_q[digit] & ~dark_q[digit];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            cnt          <= '0;
            digit        <= 3'd0;
            snapshot     <= 32'd0;
            point_q      <= 8'h00;
            le_q         <= 8'h00;
`ifdef SEG7_LZB_EN
            dark_q       <= 8'h00;
`endif
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // an and seg switch on the same edge, so no stale pattern is shown.
            if (state == SHOW && lit) begin
                an_q  <= ~(8'h01 << digit);
                seg_q <= {~point_q[digit], dec(nib)};
            end else begin
                an_q  <= 8'hFF;
                seg_q <= 8'hFF;
            end

            case (state)
                LOAD: begin
                    snapshot <= bus.disp_num;
                    point_q  <= bus.point;
                    le_q     <= bus.le;
`ifdef SEG7_LZB_EN
                    dark_q   <= lz_mask;
`endif
                    digit    <= 3'd0;
                    cnt      <= '0;
                    state    <= BLANK;
                end
                BLANK: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == BLANK_LAST) state <= SHOW;
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt <= '0;
                        if (digit == 3'd7) begin
                            state        <= LOAD;
                            frame_done_q <= 1'b1;
                        end else begin
                            digit <= digit + 3'd1;
                            state <= BLANK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver; honours SEG7_LZB_EN when defined.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int P  = 1 + 8 * SD;
    localparam logic [7:0] DEC [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    seg7_scan_if bus ();

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Reference model: frame position counted from reset release.
    int          m_c    = 0;
    int          m_next = 0;
    logic        m_rst  = 1'b1;
    logic [31:0] m_snap = '0;
    logic [7:0]  m_point = '0;
    logic [7:0]  m_le   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rst  <= 1'b1;
            m_c    <= 0;
            m_next <= 0;
        end else begin
            m_rst  <= 1'b0;
            m_c    <= m_next;
            m_next <= m_next + 1;
            if (m_next % P == 0) begin
                m_snap  <= bus.disp_num;
                m_point <= bus.point;
                m_le    <= bus.le;
            end
        end
    end

    // Returns {an, seg, frame_done} expected after the latest edge.
    function automatic logic [16:0] expect_out();
        int p, q, slot, off;
        logic fd;
        logic [3:0] nib;
        logic [7:0] pat;
        if (m_rst) return {16'hFFFF, 1'b0};
        p  = m_c % P;
        fd = (p == P - 1);
        if (p == 0) return {16'hFFFF, fd};
        q    = p - 1;
        slot = q / SD;
        off  = q % SD;
        if (off < BC || !m_le[slot]) return {16'hFFFF, fd};
`ifdef SEG7_LZB_EN
        if (slot > 0 && (m_snap >> (4 * slot)) == 32'd0) return {16'hFFFF, fd};
`endif
        nib = m_snap[4 * slot +: 4];
        pat = DEC[nib];
        return {~(8'h01 << slot), ~m_point[slot], pat[6:0], fd};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.an, bus.seg, bus.frame_done} !== {16'hFFFF, 1'b0}) begin
            errors++;
            $display("FAIL reset got %h need %h", {bus.an, bus.seg, bus.frame_done}, {16'hFFFF, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [16:0] e;
        int pulses = 0;
        int last_fd = -1;
        bus.disp_num = 32'h76543210; bus.point = 8'h00; bus.le = 8'hFF;
        do_reset();
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            e = expect_out();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e) begin
                errors++;
                $display("FAIL basic c=%0d got %h need %h", m_c, {bus.an, bus.seg, bus.frame_done}, e);
            end
            if (m_c <= 2 || m_c == 3 || m_c == 11) begin
                checks++;
                if (m_c <= 2 && {bus.an, bus.seg} !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL basic_blank c=%0d got %h need ffff", m_c, {bus.an, bus.seg});
                end else if (m_c == 3 && {bus.an, bus.seg} !== 16'hFEC0) begin
                    errors++;
                    $display("FAIL basic_dig0 got %h need fec0", {bus.an, bus.seg});
                end else if (m_c == 11 && {bus.an, bus.seg} !== 16'hFDF9) begin
                    errors++;
                    $display("FAIL basic_dig1 got %h need fdf9", {bus.an, bus.seg});
                end
            end
            if (bus.frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (m_c - last_fd != P) begin
                        errors++;
                        $display("FAIL fd_period got %0d need %0d", m_c - last_fd, P);
                    end
                end
                last_fd = m_c;
                pulses++;
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL fd_count got %0d need 2", pulses);
        end
    endtask

    task automatic test_no_tear();
        logic [16:0] e;
        bus.disp_num = 32'h76543210; bus.point = 8'h00; bus.le = 8'hFF;
        do_reset();
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            e = expect_out();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e) begin
                errors++;
                $display("FAIL tear c=%0d got %h need %h", m_c, {bus.an, bus.seg, bus.frame_done}, e);
            end
            if (m_c == P - 2 || m_c == P + 3) begin
                checks++;
                if (bus.seg !== ((m_c == P - 2) ? 8'hF8 : 8'h8E)) begin
                    errors++;
                    $display("FAIL tear_pat c=%0d got %h", m_c, bus.seg);
                end
            end
            if (i == 28) bus.disp_num = 32'hFFFFFFFF;
        end
    endtask

    task automatic test_point_le();
        logic [16:0] e;
        bus.disp_num = 32'h00000200; bus.point = 8'h04; bus.le = 8'hFF;
        do_reset();
        for (int i = 0; i < P + 1; i++) begin
            @(negedge clk);
            e = expect_out();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e) begin
                errors++;
                $display("FAIL point c=%0d got %h need %h", m_c, {bus.an, bus.seg, bus.frame_done}, e);
            end
            if (m_c == 19) begin
                checks++;
                if ({bus.an, bus.seg} !== 16'hFB24) begin
                    errors++;
                    $display("FAIL point_dig2 got %h need fb24", {bus.an, bus.seg});
                end
            end
        end
        bus.disp_num = 32'h12345678; bus.point = 8'h00; bus.le = 8'h0F;
        do_reset();
        for (int i = 0; i < P + 1; i++) begin
            @(negedge clk);
            e = expect_out();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e) begin
                errors++;
                $display("FAIL le c=%0d got %h need %h", m_c, {bus.an, bus.seg, bus.frame_done}, e);
            end
            if (m_c == 36 || m_c == P - 1) begin
                checks++;
                if ({bus.an, bus.seg, bus.frame_done} !== {16'hFFFF, m_c == P - 1}) begin
                    errors++;
                    $display("FAIL le_dark c=%0d got %h", m_c, {bus.an, bus.seg, bus.frame_done});
                end
            end
        end
    endtask

    task automatic test_lzb();
        logic [16:0] e;
        logic [15:0] need2;
`ifdef SEG7_LZB_EN
        need2 = 16'hFFFF;
`else
        need2 = 16'hFBC0;
`endif
        bus.disp_num = 32'h000000A0; bus.point = 8'h00; bus.le = 8'hFF;
        do_reset();
        for (int i = 0; i < P + 1; i++) begin
            @(negedge clk);
            e = expect_out();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e) begin
                errors++;
                $display("FAIL lzb c=%0d got %h need %h", m_c, {bus.an, bus.seg, bus.frame_done}, e);
            end
            if (m_c == 11 || m_c == 19) begin
                checks++;
                if ({bus.an, bus.seg} !== ((m_c == 11) ? 16'hFD88 : need2)) begin
                    errors++;
                    $display("FAIL lzb_dig c=%0d got %h", m_c, {bus.an, bus.seg});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] e;
        bus.disp_num = $urandom; bus.point = 8'($urandom_range(0, 255)); bus.le = 8'($urandom_range(0, 255));
        do_reset();
        for (int i = 0; i < 4 * P; i++) begin
            @(negedge clk);
            e = expect_out();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e) begin
                errors++;
                $display("FAIL random c=%0d got %h need %h", m_c, {bus.an, bus.seg, bus.frame_done}, e);
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.disp_num = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4095)) : $urandom;
                bus.point    = 8'($urandom_range(0, 255));
                bus.le       = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] e;
        bus.disp_num = $urandom; bus.point = 8'h00; bus.le = 8'hFF;
        do_reset();
        for (int i = 0; i < 46; i++) @(negedge clk);
        rst = 1'b1;
        bus.disp_num = $urandom; bus.point = 8'($urandom_range(0, 255));
        @(negedge clk);
        checks++;
        if ({bus.an, bus.seg, bus.frame_done} !== {16'hFFFF, 1'b0}) begin
            errors++;
            $display("FAIL midrst got %h need %h", {bus.an, bus.seg, bus.frame_done}, {16'hFFFF, 1'b0});
        end
        rst = 1'b0;
        for (int i = 0; i < P + 8; i++) begin
            @(negedge clk);
            e = expect_out();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== e) begin
                errors++;
                $display("FAIL midrst_run c=%0d got %h need %h", m_c, {bus.an, bus.seg, bus.frame_done}, e);
            end
        end
    endtask

    initial begin
        bus.disp_num = 32'd0;
        bus.point    = 8'h00;
        bus.le       = 8'h00;
        test_reset();
        test_basic();
        test_no_tear();
        test_point_le();
        test_lzb();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed 8-digit 7-segment scan driver. Sits directly downstream of the GPIO 7-seg display register and consumes its 32-bit disp_num word. Snapshots the word once per frame, decodes one hex nibble per digit slot, and drives active-low anode and segment lines to the board. Inserts a blanking gap between digits to suppress ghosting.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot, including blanking; legal range >= 2
BLANK_CYC, 500, cycles at the start of each slot with all anodes off; legal range 1 .. SCAN_DIV-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
disp_num  input  32  display word; nibble d = disp_num[4d+3:4d], digit 0 rightmost
point  input  8  decimal point per digit, 1 = lit
le  input  8  digit enable per digit, 1 = digit may light
an  output  8  anodes, active-low; an[d] selects digit d
seg  output  8  segments, active-low; seg[7] = dp, seg[6:0] = g..a
frame_done  output  1  one-cycle pulse when the digit-7 slot ends

Behaviour:
- Reset (rst=1 at a clk edge): an=8'hFF, seg=8'hFF, frame_done=0. Internal state: state=LOAD, cnt=0, digit=0, snapshot/point_q/le_q=0.
- Reset asserted mid-frame: outputs are FF on the next edge. After release, the frame restarts at LOAD with digit 0.
- FSM states are LOAD, BLANK and SHOW.
- LOAD, one cycle:
  - snapshot<=disp_num, point_q<=point, le_q<=le, digit<=0, cnt<=0.
  - Next state is BLANK.
- BLANK:
  - cnt increments each cycle.
  - When cnt==BLANK_CYC-1, go to SHOW; cnt keeps counting.
- SHOW:
  - cnt increments each cycle.
  - When cnt==SCAN_DIV-1: cnt<=0.
  - If digit==7: go to LOAD and pulse frame_done for that cycle.
  - Otherwise: digit<=digit+1 and go to BLANK.
- Slot timing: each slot is BLANK_CYC blank cycles followed by SCAN_DIV-BLANK_CYC show cycles.
- Frame period: 1+8*SCAN_DIV cycles.
- Outputs are registered with one-cycle latency: an/seg at cycle N+1 reflect state/digit at cycle N.
- Output values by state:
  - LOAD or BLANK: an=FF, seg=FF.
  - SHOW with le_q[digit]=0: an=FF, seg=FF.
  - SHOW with le_q[digit]=1: an=~(8'h01<<digit), seg={~point_q[digit], dec(nib)}.
- dec() table (byte values, bit7 set = dp off), value -> byte:
  - 0->C0, 1->F9, 2->A4, 3->B0
  - 4->99, 5->92, 6->82, 7->F8
  - 8->80, 9->90, A->88, b->83
  - C->C6, d->A1, E->86, F->8E
  - seg[6:0] takes bits [6:0] of the entry.
- disp_num, point and le changes mid-frame are ignored until the next LOAD, so a frame never tears.
- At most one anode is low in any cycle. No cycle exists with an anode low while seg holds the previous digit's pattern.
- The cnt width is sized to hold SCAN_DIV-1. The counter never wraps except through the explicit reset to 0.

Optional Feature:
SEG7_LZB_EN, leading-zero blanking.
- Defined: in SHOW, digit d>0 is forced dark (an=FF, seg=FF) when snapshot nibbles d..7 are all zero. Digit 0 always lights if le_q[0]=1. The zero mask is computed at LOAD from the snapshot.
- Undefined: every enabled digit is displayed, including leading zeros.

Test Plan:
1. SCAN_DIV=8, BLANK_CYC=2, disp_num=32'h76543210, point=0, le=FF, rst pulsed then released -> an=FF/seg=FF through LOAD+2 blank cycles. Then an=FE, seg=C0 for 6 cycles; then 2 blank cycles; then an=FD, seg=F9. frame_done pulses every 65 cycles.
2. Same config, disp_num changed to 32'hFFFFFFFF during the digit-3 slot -> digits 3..7 still show 30..76 patterns (B0,99,92,82,F8). The next frame shows 8E on all digits.
3. point=8'h04, disp_num=32'h00000200 -> digit-2 slot shows an=FB, seg=24 (A4 with dp bit cleared). All other digits have seg[7]=1.
4. le=8'h0F -> an stays FF and seg FF during slots 4..7. Slots 0..3 light normally. frame_done timing is unchanged.
5. disp_num=32'h000000A0:
   - With SEG7_LZB_EN: only digits 0 (C0) and 1 (88) light; slots 2..7 are dark.
   - Without SEG7_LZB_EN: digits 2..7 show C0.
6. rst asserted for 1 cycle mid-SHOW of digit 5 -> an=FF, seg=FF, frame_done=0 on the next edge. After release, the sequence restarts at LOAD with digit 0, and the new snapshot is taken.
